// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
//   XLEN             : datapath width
//   NOP_INSTR        : canonical RV32 NOP (addi x0,x0,0) returned by memory in reset
//   DEFAULT_RESET_PC : default PC after reset
//   fetch_entry_t    : one buffered fetch {pc, instr}
package fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: fetch-to-decode handshake plus redirect request.
//   fetch_valid/fetch_instr/fetch_pc : head of the fetch buffer (fetch -> decode)
//   fetch_ready                      : decode accepts the head
//   redirect_valid/redirect_pc       : control-flow change request (decode/exec -> fetch)
// modport master: the fetch unit side; modport slave: the consumer side.
interface instr_fetch_unit_if;
   import fetch_pkg::*;

   logic            fetch_valid;
   logic [XLEN-1:0] fetch_instr;
   logic [XLEN-1:0] fetch_pc;
   logic            fetch_ready;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   modport master (
      output fetch_valid, fetch_instr, fetch_pc,
      input  fetch_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  fetch_valid, fetch_instr, fetch_pc,
      output fetch_ready, redirect_valid, redirect_pc
   );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of fetch_entry_t.
//   clk, reset : clock, synchronous active-high reset
//   flush      : discard all entries (takes priority over push/pop)
//   push/push_data : write one entry at the tail
//   pop        : drop the head entry
//   head       : current head entry (contents undefined when count == 0)
//   count      : number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap without extra logic.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  fetch_entry_t                 push_data,
   input  logic                         pop,
   output fetch_entry_t                 head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;

   assign head = mem[rd_ptr];

   // Storage is not reset; count gates every use of the head.
   always_ff @(posedge clk) begin
      if (push && !flush && !reset)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32 fetch initiator.
// Owns the PC, issues word addresses to a 1-cycle-latency instruction memory,
// buffers returned {pc, instr} pairs and hands them to decode over valid/ready.
// A redirect flushes the buffer and any in-flight fetch and restarts at the target.
//   clk, reset  : clock, synchronous active-high reset
//   imem_pc     : registered fetch address (pc_q)
//   imem_instr  : memory read data for the address sampled on the previous edge
//   fif         : decode handshake and redirect request (master modport)
//   pc_fault    : sticky PC duplicate-mismatch flag
// Build option: FETCH_PC_DMR_EN adds a shadow PC and drives pc_fault;
// without it pc_fault is tied low.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              DEPTH    = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic [XLEN-1:0]      imem_pc,
   input  logic [XLEN-1:0]      imem_instr,
   instr_fetch_unit_if.master   fif,
   output logic                 pc_fault
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int OW = CW + 1;

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic            rsp_valid_q;
   logic [XLEN-1:0] rsp_pc_q;

   logic [CW-1:0]   count;
   fetch_entry_t    head;
   fetch_entry_t    push_data;
   logic            push;
   logic            pop;
   logic            issue;
   logic [OW-1:0]   occ;
   logic [XLEN-1:0] redirect_tgt;
   logic            unused_rpc_lo;

   assign redirect_tgt  = {fif.redirect_pc[XLEN-1:2], 2'b00};
   assign unused_rpc_lo = ^fif.redirect_pc[1:0];

   assign fif.fetch_valid = (count != '0);
   assign fif.fetch_instr = fif.fetch_valid ? head.instr : '0;
   assign fif.fetch_pc    = fif.fetch_valid ? head.pc    : '0;

   assign pop  = fif.fetch_valid && fif.fetch_ready;
   assign push = rsp_valid_q && !fif.redirect_valid;
   assign push_data = '{pc: rsp_pc_q, instr: imem_instr};

   // Occupancy after this edge if we issue now: the in-flight word will land
   // next cycle, so it reserves a slot. pop implies count >= 1, no underflow.
   assign occ   = {1'b0, count} + OW'(rsp_valid_q) - OW'(pop);
   assign issue = !fif.redirect_valid && (occ < OW'(DEPTH));

   always_comb begin
      pc_d = pc_q;
      if (fif.redirect_valid) pc_d = redirect_tgt;
      else if (issue)         pc_d = pc_q + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         rsp_valid_q <= 1'b0;
         rsp_pc_q    <= '0;
      end else begin
         pc_q        <= pc_d;
         rsp_valid_q <= issue;
         if (issue) rsp_pc_q <= pc_q;
      end
   end

   assign imem_pc = pc_q;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (fif.redirect_valid),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

`ifdef FETCH_PC_DMR_EN
   // Shadow PC follows the same next-state rule from its own value, so any
   // upset in either copy shows up as a persistent mismatch.
   logic [XLEN-1:0] pc_shadow_q;
   logic [XLEN-1:0] pc_shadow_d;
   logic            pc_fault_q;

   always_comb begin
      pc_shadow_d = pc_shadow_q;
      if (fif.redirect_valid) pc_shadow_d = redirect_tgt;
      else if (issue)         pc_shadow_d = pc_shadow_q + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_shadow_q <= RESET_PC;
         pc_fault_q  <= 1'b0;
      end else begin
         pc_shadow_q <= pc_shadow_d;
         pc_fault_q  <= pc_fault_q | (pc_q != pc_shadow_q);
      end
   end

   assign pc_fault = pc_fault_q;
`else
   assign pc_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit.
// A behavioural 1-cycle memory feeds the DUT. Whenever the bench starts a new
// fetch stream (reset release or redirect) it pushes the expected {pc, instr}
// sequence into a queue; every decode handshake pops and compares one entry.
module tb_instr_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        pc_fault;

   instr_fetch_unit_if fif ();

   instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_pc    (imem_pc),
      .imem_instr (imem_instr),
      .fif        (fif.master),
      .pc_fault   (pc_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0: return 32'h0000_0013;
         32'h4: return 32'h0010_0093;
         32'h8: return 32'h0020_0113;
         default: return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
      endcase
   endfunction

   always @(posedge clk)
      imem_instr <= reset ? NOP_INSTR : mem_word(imem_pc);

   int n_chk  = 0;
   int n_fail = 0;
   int n_pop  = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   fetch_entry_t sb[$];
   logic [31:0]  next_pc;

   task automatic sb_topup();
      while (sb.size() < 32) begin
         sb.push_back('{pc: next_pc, instr: mem_word(next_pc)});
         next_pc = next_pc + 32'd4;
      end
   endtask

   task automatic sb_restart(input logic [31:0] pc);
      sb.delete();
      next_pc = pc;
      sb_topup();
   endtask

   // Samples taken #1 after the falling edge, i.e. state after the last rise.
   logic        s_valid;
   logic [31:0] s_pc, s_instr, s_imem;
   logic        s_fault;
   logic        prev_hold = 1'b0;
   logic [31:0] hold_pc, hold_instr;

   task automatic step(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
      fetch_entry_t e;
      @(negedge clk);
      reset              = rst;
      fif.fetch_ready    = rdy;
      fif.redirect_valid = rv;
      fif.redirect_pc    = rpc;
      #1;
      s_valid = fif.fetch_valid;
      s_pc    = fif.fetch_pc;
      s_instr = fif.fetch_instr;
      s_imem  = imem_pc;
      s_fault = pc_fault;
      if (prev_hold) begin
         check("hold_valid", {31'd0, s_valid}, 32'd1);
         check("hold_pc", s_pc, hold_pc);
         check("hold_instr", s_instr, hold_instr);
      end
      prev_hold  = s_valid && !rdy && !rv && !rst;
      hold_pc    = s_pc;
      hold_instr = s_instr;
      if (s_valid === 1'b1 && rdy) begin
         n_pop++;
         if (sb.size() == 0) check("sb_underflow", s_pc, 32'hDEAD_BEEF);
         else begin
            e = sb.pop_front();
            check("fetch_pc", s_pc, e.pc);
            check("fetch_instr", s_instr, e.instr);
            sb_topup();
         end
      end
      if (rst)     sb_restart(RESET_PC);
      else if (rv) sb_restart({rpc[31:2], 2'b00});
   endtask

   initial begin
      reset = 1'b1;
      fif.fetch_ready = 1'b1;
      fif.redirect_valid = 1'b0;
      fif.redirect_pc = '0;

      // Reset state
      repeat (3) step(1, 1, 0, 0);
      check("rst_imem_pc", s_imem, RESET_PC);
      check("rst_valid", {31'd0, s_valid}, 32'd0);
      check("rst_fetch_pc", s_pc, 32'd0);
      check("rst_fetch_instr", s_instr, 32'd0);
      check("rst_fault", {31'd0, s_fault}, 32'd0);

      // Release: valid appears on the 2nd cycle, then one per cycle
      n_pop = 0;
      step(0, 1, 0, 0); check("rel_c0_valid", {31'd0, s_valid}, 32'd0);
      step(0, 1, 0, 0); check("rel_c1_valid", {31'd0, s_valid}, 32'd0);
      step(0, 1, 0, 0); check("rel_c2_valid", {31'd0, s_valid}, 32'd1);
      repeat (6) step(0, 1, 0, 0);
      check("stream_pops", n_pop, 32'd7);

      // Back-pressure from PC 0
      step(0, 0, 1, 32'h0);
      repeat (5) step(0, 0, 0, 0);
      check("bp_imem_stall", s_imem, 32'h8);
      check("bp_valid", {31'd0, s_valid}, 32'd1);
      check("bp_head_pc", s_pc, 32'h0);
      n_pop = 0;
      repeat (8) step(0, 1, 0, 0);
      check("bp_release_pops", n_pop, 32'd8);

      // Redirect to unaligned target with a full buffer
      repeat (3) step(0, 0, 0, 0);
      step(0, 0, 1, 32'h0000_0023);
      step(0, 1, 0, 0); check("rd_bubble0", {31'd0, s_valid}, 32'd0);
      step(0, 1, 0, 0); check("rd_bubble1", {31'd0, s_valid}, 32'd0);
      step(0, 1, 0, 0); check("rd_first_valid", {31'd0, s_valid}, 32'd1);
      check("rd_first_pc", s_pc, 32'h20);
      repeat (4) step(0, 1, 0, 0);

      // Redirect coinciding with a pop while a fetch is in flight
      n_pop = 0;
      step(0, 1, 1, 32'h0000_0100);
      check("rdpop_popped", n_pop, 32'd1);
      step(0, 1, 0, 0); check("rdpop_bubble0", {31'd0, s_valid}, 32'd0);
      step(0, 1, 0, 0); check("rdpop_bubble1", {31'd0, s_valid}, 32'd0);
      step(0, 1, 0, 0); check("rdpop_pc", s_pc, 32'h100);
      repeat (3) step(0, 1, 0, 0);

      // Address wrap
      n_pop = 0;
      step(0, 1, 1, 32'hFFFF_FFF8);
      repeat (2) step(0, 1, 0, 0);
      step(0, 1, 0, 0); check("wrap_pc0", s_pc, 32'hFFFF_FFF8);
      step(0, 1, 0, 0); check("wrap_pc1", s_pc, 32'hFFFF_FFFC);
      step(0, 1, 0, 0); check("wrap_pc2", s_pc, 32'h0000_0000);
      check("wrap_pops", n_pop, 32'd4);

      // Random ready / redirect traffic
      n_pop = 0;
      for (int i = 0; i < 300; i++) begin
         logic       r;
         logic       rv;
         logic [31:0] t;
         r  = ($urandom_range(0, 3) != 0);
         rv = ($urandom_range(0, 15) == 0);
         t  = $urandom_range(0, 32'h0000_FFFF);
         step(0, r, rv, t);
      end
      check("rand_progress", {31'd0, (n_pop > 100)}, 32'd1);

      // Reset mid-operation overrides a redirect
      step(1, 1, 1, 32'h0000_0500);
      step(0, 1, 0, 0);
      check("mid_rst_imem_pc", s_imem, RESET_PC);
      check("mid_rst_valid", {31'd0, s_valid}, 32'd0);
      check("mid_rst_fetch_pc", s_pc, 32'd0);
      step(0, 1, 0, 0); check("mid_rst_c1_valid", {31'd0, s_valid}, 32'd0);
      step(0, 1, 0, 0); check("mid_rst_c2_pc", s_pc, RESET_PC);
      repeat (100) step(0, 1, 0, 0);
      check("clean_fault", {31'd0, s_fault}, 32'd0);

`ifdef FETCH_PC_DMR_EN
      @(negedge clk);
      force dut.pc_shadow_q = dut.pc_q ^ 32'h0000_0010;
      @(posedge clk);
      #1 release dut.pc_shadow_q;
      step(0, 1, 0, 0); check("dmr_fault_set", {31'd0, s_fault}, 32'd1);
      repeat (5) step(0, 1, 0, 0);
      check("dmr_fault_sticky", {31'd0, s_fault}, 32'd1);
      step(1, 1, 0, 0);
      step(0, 1, 0, 0); check("dmr_fault_cleared", {31'd0, s_fault}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
